// File: rtl/iter_shifter.sv
// Iterative one-bit-per-clock shifter (SLL/SRL/SRA/ROR) with a start/busy/done handshake
// for the multicycle control unit; the result feeds the register-file write-back mux.
module iter_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            shift_op,
    input  logic [AMT_WIDTH-1:0]  shamt_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [AMT_WIDTH-1:0]  CNT_ZERO = {AMT_WIDTH{1'b0}};
    localparam logic [AMT_WIDTH-1:0]  CNT_ONE  = {{(AMT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ACC_ZERO = {DATA_WIDTH{1'b0}};

    // Single-position shift of the accumulator for the latched operation.
    function automatic logic [DATA_WIDTH-1:0] shift_step(
        input logic [DATA_WIDTH-1:0] value,
        input logic [1:0]            op
    );
        logic [DATA_WIDTH-1:0] res;
        case (op)
            OP_SLL:  res = {value[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  res = {1'b0, value[DATA_WIDTH-1:1]};
            OP_SRA:  res = {value[DATA_WIDTH-1], value[DATA_WIDTH-1:1]};
            OP_ROR:  res = {value[0], value[DATA_WIDTH-1:1]};
            default: res = value;
        endcase
        return res;
    endfunction

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] acc_r, acc_s;
    logic [AMT_WIDTH-1:0]  cnt_r, cnt_s;
    logic [1:0]            op_r, op_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;

    // Next-state, datapath update and next-output decode.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_s = data_in;
                    cnt_s = shamt_in;
                    op_s  = shift_op;
                    if (shamt_in != CNT_ZERO) begin
                        state_s = ST_SHIFT;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_s = shift_step(acc_r, op_r);
                // cnt is always >= 1 here, so the decrement cannot wrap.
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Handshake flags are registered from the next state, so they track state exactly.
        if ((state_s == ST_SHIFT) || (state_s == ST_DONE)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        if (state_s == ST_DONE) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            acc_r   <= ACC_ZERO;
            cnt_r   <= CNT_ZERO;
            op_r    <= OP_SLL;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign data_out = acc_r;

endmodule
